aplic_msi_notifier: RTL and testbench

MSI-mode delivery stage of the APLIC domain. It scans the domain's pending and enabled sources and fetches each source's target register. It then forms an MSI write (address from the msiaddrcfg base, hart index and guest index; data equal to the EIID) and drives it to the bus master over a valid/ready handshake. It also services the genmsi register and clears each source's pending bit once its MSI is accepted.

---
 rtl/aplic_pkg.sv | 41 ++++
 rtl/aplic_msi_addr_gen.sv | 20 ++
 rtl/aplic_msi_notifier.sv | 188 ++++++++++++++++++
 tb/tb_aplic_msi_notifier.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aplic_pkg.sv
// Shared APLIC types: register layouts, MSI delivery FSM states and constants.
package aplic_pkg;

  localparam int MSI_PAGE_SHIFT = 12;
  localparam int HART_IDX_W     = 14;
  localparam int GUEST_IDX_W    = 6;
  localparam int EIID_W         = 11;

  typedef logic [HART_IDX_W-1:0]  hart_index_t;
  typedef logic [GUEST_IDX_W-1:0] guest_index_t;
  typedef logic [EIID_W-1:0]      eiid_t;

  // genmsi register: hart index, busy flag, EIID.
  typedef struct packed {
    hart_index_t hi;
    logic [4:0]  rsv1;
    logic        busy;
    logic        rsv0;
    eiid_t       eiid;
  } genmsi_t;

  // Raw target register word.
  typedef logic [31:0] target_t;

  // Target register as seen in MSI delivery mode.
  typedef struct packed {
    hart_index_t  hi;
    guest_index_t gi;
    logic         rsv;
    eiid_t        eiid;
  } target_msi_field_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    RD_TGT,
    LATCH,
    SEND
  } aplic_msi_fsm_t;

endpackage

// File: rtl/aplic_msi_addr_gen.sv
// MSI target address: base plus the interrupt-file page selected by hart and guest index.
module aplic_msi_addr_gen
  import aplic_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] i_base,
  input  logic [2:0]        i_lhxs,
  input  hart_index_t       i_hi,
  input  guest_index_t      i_gi,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] page_idx;

  // Hart index sits above the guest index field; the result selects a 4 KiB page.
  assign page_idx = (ADDR_W'(i_hi) << i_lhxs) | ADDR_W'(i_gi);
  assign o_addr   = i_base + (page_idx << MSI_PAGE_SHIFT);

endmodule

// File: rtl/aplic_msi_notifier.sv
// MSI-mode delivery: scans pending+enabled sources round-robin, fetches each
// target register, issues the MSI write and clears pending on acceptance.
// Also issues software-generated MSIs from the genmsi register.
module aplic_msi_notifier
  import aplic_pkg::*;
#(
  parameter int NR_SRC = 64,
  parameter int SRC_W  = $clog2(NR_SRC),
  parameter int ADDR_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_domaincfg_ie,
  input  logic              i_domaincfg_dm,
  input  logic [NR_SRC-1:0] i_ip,
  input  logic [NR_SRC-1:0] i_ie,
  output logic              o_tgt_rd_en,
  output logic [SRC_W-1:0]  o_tgt_rd_idx,
  input  logic [31:0]       i_tgt_rd_data,
  input  logic [ADDR_W-1:0] i_msi_base,
  input  logic [2:0]        i_lhxs,
  input  logic              i_genmsi_we,
  input  logic [31:0]       i_genmsi_wdata,
  output logic [31:0]       o_genmsi,
  output logic              o_clr_ip_valid,
  output logic [SRC_W-1:0]  o_clr_ip_idx,
  output logic              o_msi_valid,
  input  logic              i_msi_ready,
  output logic [ADDR_W-1:0] o_msi_addr,
  output logic [31:0]       o_msi_data
);

  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NR_SRC - 1);

  // Source 0 does not exist, so the scan wraps from the last source to 1.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] p);
    return (p == LAST_SRC) ? SRC_W'(1) : p + SRC_W'(1);
  endfunction

  aplic_msi_fsm_t    state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  hart_index_t       hi_q, hi_d;
  guest_index_t      gi_q, gi_d;
  eiid_t             eiid_q, eiid_d;
  logic              from_genmsi_q, from_genmsi_d;
  genmsi_t           genmsi_q, genmsi_d;

  logic              enabled;
  logic              src_hit;
  logic              genmsi_clr;
  target_msi_field_t tgt;
  genmsi_t           genmsi_wr;
  logic [ADDR_W-1:0] msi_addr;
  logic              unused_bits;

  assign enabled   = i_domaincfg_ie & i_domaincfg_dm;
  assign src_hit   = i_ip[ptr_q] & i_ie[ptr_q];
  assign tgt       = target_msi_field_t'(i_tgt_rd_data);
  assign genmsi_wr = genmsi_t'(i_genmsi_wdata);

  assign unused_bits = ^{tgt.rsv, genmsi_wr.rsv1, genmsi_wr.busy, genmsi_wr.rsv0};

  // Next-state logic, handshake outputs and capture of the MSI being built.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    state_d        = state_q;
    ptr_d          = ptr_q;
    hi_d           = hi_q;
    gi_d           = gi_q;
    eiid_d         = eiid_q;
    from_genmsi_d  = from_genmsi_q;
    o_clr_ip_valid = 1'b0;
    o_msi_valid    = 1'b0;
    genmsi_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enabled) state_d = SCAN;
      end
      SCAN: begin
        if (!enabled) begin
          state_d = IDLE;
        end else if (genmsi_q.busy) begin
          hi_d          = genmsi_q.hi;
          gi_d          = '0;
          eiid_d        = genmsi_q.eiid;
          from_genmsi_d = 1'b1;
          state_d       = SEND;
        end else if (src_hit) begin
          state_d = RD_TGT;
        end else begin
          ptr_d = next_src(ptr_q);
        end
      end
      RD_TGT: begin
        state_d = enabled ? LATCH : IDLE;
      end
      LATCH: begin
        if (!enabled) begin
          state_d = IDLE;
        end else begin
          hi_d          = tgt.hi;
          gi_d          = tgt.gi;
          eiid_d        = tgt.eiid;
          from_genmsi_d = 1'b0;
          if (!src_hit) begin
            // Source dropped while its target was being read: skip it silently.
            state_d = SCAN;
            ptr_d   = next_src(ptr_q);
          end else if (tgt.eiid == '0) begin
            // EIID 0 means "no interrupt identity": retire the source without a write.
            o_clr_ip_valid = 1'b1;
            state_d        = SCAN;
            ptr_d          = next_src(ptr_q);
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        // Domain config changes are ignored here so a posted request always completes.
        o_msi_valid = 1'b1;
        if (i_msi_ready) begin
          state_d = SCAN;
          if (from_genmsi_q) begin
            genmsi_clr = 1'b1;
          end else begin
            o_clr_ip_valid = 1'b1;
            ptr_d          = next_src(ptr_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // genmsi register: software load when idle, hardware clear on acceptance (clear wins).
  always_comb begin
    genmsi_d = genmsi_q;
    if (genmsi_clr) begin
      genmsi_d.busy = 1'b0;
    end else if (i_genmsi_we && !genmsi_q.busy) begin
      genmsi_d      = '0;
      genmsi_d.hi   = genmsi_wr.hi;
      genmsi_d.eiid = genmsi_wr.eiid;
      genmsi_d.busy = 1'b1;
    end
  end

  // State register; reset abandons any in-flight MSI without touching pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      ptr_q         <= SRC_W'(1);
      hi_q          <= '0;
      gi_q          <= '0;
      eiid_q        <= '0;
      from_genmsi_q <= 1'b0;
      genmsi_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hi_q          <= hi_d;
      gi_q          <= gi_d;
      eiid_q        <= eiid_d;
      from_genmsi_q <= from_genmsi_d;
      genmsi_q      <= genmsi_d;
    end
  end

  aplic_msi_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_base (i_msi_base),
    .i_lhxs (i_lhxs),
    .i_hi   (hi_q),
    .i_gi   (gi_q),
    .o_addr (msi_addr)
  );

  assign o_tgt_rd_en  = (state_q == RD_TGT);
  assign o_tgt_rd_idx = o_tgt_rd_en ? ptr_q : '0;
  assign o_clr_ip_idx = o_clr_ip_valid ? ptr_q : '0;
  assign o_genmsi     = genmsi_q;
  assign o_msi_addr   = o_msi_valid ? msi_addr : '0;
  assign o_msi_data   = o_msi_valid ? {21'b0, eiid_q} : '0;

endmodule

// File: tb/tb_aplic_msi_notifier.sv
// Bench for aplic_msi_notifier: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the MSI delivery rules.
module tb_aplic_msi_notifier;

  localparam int NR_SRC = 64;
  localparam int SRC_W  = 6;
  localparam int ADDR_W = 64;
  localparam int K_SRC  = 0;
  localparam int K_GM   = 1;
  localparam int K_ZERO = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dc_ie, dc_dm;
  logic [NR_SRC-1:0] ip_q = '0;
  logic [NR_SRC-1:0] ie, ip_set, ip_kill;
  logic              rd_en;
  logic [SRC_W-1:0]  rd_idx;
  logic [31:0]       rd_data = '0;
  logic [ADDR_W-1:0] base;
  logic [2:0]        lhxs;
  logic              gm_we;
  logic [31:0]       gm_wdata;
  logic [31:0]       genmsi;
  logic              clr_v;
  logic [SRC_W-1:0]  clr_idx;
  logic              msi_v, msi_rdy;
  logic [ADDR_W-1:0] msi_addr;
  logic [31:0]       msi_data;
  logic [31:0]       tgt [NR_SRC];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t ev_q[$];

  aplic_msi_notifier #(
    .NR_SRC (NR_SRC),
    .SRC_W  (SRC_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_domaincfg_ie (dc_ie),
    .i_domaincfg_dm (dc_dm),
    .i_ip           (ip_q),
    .i_ie           (ie),
    .o_tgt_rd_en    (rd_en),
    .o_tgt_rd_idx   (rd_idx),
    .i_tgt_rd_data  (rd_data),
    .i_msi_base     (base),
    .i_lhxs         (lhxs),
    .i_genmsi_we    (gm_we),
    .i_genmsi_wdata (gm_wdata),
    .o_genmsi       (genmsi),
    .o_clr_ip_valid (clr_v),
    .o_clr_ip_idx   (clr_idx),
    .o_msi_valid    (msi_v),
    .i_msi_ready    (msi_rdy),
    .o_msi_addr     (msi_addr),
    .o_msi_data     (msi_data)
  );

  always #5 clk = ~clk;

  // Pending-bit register owned by the bench: set by stimulus, cleared by the DUT's pulse.
  always @(posedge clk)
    ip_q <= (ip_q | ip_set) & ~ip_kill & ~(clr_v ? (NR_SRC'(1) << clr_idx) : NR_SRC'(0));

  // Target register file with one cycle of read latency.
  always @(posedge clk)
    if (rd_en) rd_data <= tgt[rd_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_tgt(input int unsigned hi, input int unsigned gi,
                                         input int unsigned eiid);
    return 32'((hi % 16384) * 262144 + (gi % 64) * 4096 + (eiid % 2048));
  endfunction

  // Address rule: base + (((hi << lhxs) | gi) << 12).
  function automatic logic [63:0] exp_addr(input int unsigned hi, input int unsigned gi);
    logic [63:0] page;
    page = (64'(hi) * (64'd1 << lhxs)) | 64'(gi);
    return base + page * 64'd4096;
  endfunction

  // ---------------- model / monitor ----------------
  logic        m_busy = 1'b0;
  int unsigned m_hi = 0, m_eiid = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr;
  logic [31:0] prev_data;
  int          cyc = 0, last_rd_cyc = 0, vstart_cyc = 0, rd_cnt = 0, v_cnt = 0;
  logic        prev_v = 1'b0;
  int unsigned t_hi, t_gi, t_eiid;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_hi = 0; m_eiid = 0;
      prev_stall = 1'b0; prev_v = 1'b0;
    end else begin
      check("genmsi_readback", 64'(genmsi),
            64'(m_hi * 262144 + (m_busy ? 4096 : 0) + m_eiid));
      if (msi_v && prev_stall) begin
        check("stall_addr_stable", msi_addr, prev_addr);
        check("stall_data_stable", 64'(msi_data), 64'(prev_data));
      end
      if (rd_en) begin
        check("rd_idx_not_zero", 64'(rd_idx != 0), 64'd1);
        last_rd_cyc = cyc;
        rd_cnt++;
      end
      if (msi_v) v_cnt++;
      if (msi_v && !prev_v) vstart_cyc = cyc;
      if (msi_v && msi_rdy) begin
        if (clr_v) begin
          t_hi = int'(tgt[clr_idx][31:18]); t_gi = int'(tgt[clr_idx][17:12]);
          t_eiid = int'(tgt[clr_idx][10:0]);
          check("src_was_pending", 64'(ip_q[clr_idx] & ie[clr_idx]), 64'd1);
          check("src_eiid_nonzero", 64'(t_eiid != 0), 64'd1);
          check("src_addr", msi_addr, exp_addr(t_hi, t_gi));
          check("src_data", 64'(msi_data), 64'(t_eiid));
          ev_q.push_back('{K_SRC, int'(clr_idx), msi_addr, msi_data});
        end else begin
          check("gm_was_busy", 64'(m_busy), 64'd1);
          check("gm_addr", msi_addr, exp_addr(m_hi, 0));
          check("gm_data", 64'(msi_data), 64'(m_eiid));
          ev_q.push_back('{K_GM, 0, msi_addr, msi_data});
        end
      end else if (clr_v) begin
        check("zero_eiid_target", 64'(tgt[clr_idx][10:0]), 64'd0);
        check("zero_was_pending", 64'(ip_q[clr_idx] & ie[clr_idx]), 64'd1);
        ev_q.push_back('{K_ZERO, int'(clr_idx), 64'd0, 32'd0});
      end
      // genmsi rule: acceptance clears busy; a write loads only when not busy.
      if (msi_v && msi_rdy && !clr_v) m_busy = 1'b0;
      else if (gm_we && !m_busy) begin
        m_hi = int'(gm_wdata[31:18]); m_eiid = int'(gm_wdata[10:0]); m_busy = 1'b1;
      end
      prev_stall = msi_v && !msi_rdy;
      prev_addr  = msi_addr;
      prev_data  = msi_data;
      prev_v     = msi_v;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; ip_kill = '1; ip_set = '0; gm_we = 1'b0; msi_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 ip_kill = '0; rst = 1'b0;
    ev_q.delete();
  endtask

  task automatic set_ip(input logic [NR_SRC-1:0] m);
    @(posedge clk); #1 ip_set = m;
    @(posedge clk); #1 ip_set = '0;
  endtask

  task automatic genmsi_write(input int unsigned hi, input int unsigned eiid);
    @(posedge clk); #1 gm_we = 1'b1; gm_wdata = mk_tgt(hi, 0, eiid) | 32'h0000_1000;
    @(posedge clk); #1 gm_we = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!msi_v && n < 200) begin @(negedge clk); n++; end
    check(name, 64'(msi_v), 64'd1);
  endtask

  task automatic wait_events(input int cnt, input string name);
    int n = 0;
    while (ev_q.size() < cnt && n < 400) begin @(negedge clk); n++; end
    check(name, 64'(ev_q.size() >= cnt), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, actual hang required finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] saved;
    dc_ie = 1'b1; dc_dm = 1'b1; ie = '1; ie[0] = 1'b0; ip_set = '0; ip_kill = '1;
    base = 64'h2800_0000; lhxs = 3'd0; gm_we = 1'b0; gm_wdata = '0; msi_rdy = 1'b1;
    for (int i = 0; i < NR_SRC; i++) tgt[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_idx", 64'(rd_idx), 64'd0);
    check("rst_genmsi", 64'(genmsi), 64'd0);
    check("rst_clr_v", 64'(clr_v), 64'd0);
    check("rst_msi_v", 64'(msi_v), 64'd0);
    check("rst_msi_addr", msi_addr, 64'd0);
    check("rst_msi_data", 64'(msi_data), 64'd0);
    do_reset();

    // 1: single source, literal address/data, latency, no re-send until re-pended
    tgt[5] = mk_tgt(3, 2, 'h21);
    set_ip(NR_SRC'(1) << 5);
    wait_events(1, "t1_event");
    if (ev_q.size() >= 1) begin
      check("t1_kind", 64'(ev_q[0].kind), 64'(K_SRC));
      check("t1_idx", 64'(ev_q[0].idx), 64'd5);
      check("t1_addr", ev_q[0].addr, 64'h2800_3000);
      check("t1_data", 64'(ev_q[0].data), 64'h21);
      check("t1_latency", 64'(vstart_cyc - last_rd_cyc), 64'd2);
    end
    repeat (80) @(negedge clk);
    check("t1_no_resend", 64'(ev_q.size()), 64'd1);
    check("t1_ip_cleared", 64'(ip_q[5]), 64'd0);
    set_ip(NR_SRC'(1) << 5);
    wait_events(2, "t1_resend");

    // 2: stall stability, scan order, wrap past source 0
    do_reset();
    tgt[0] = mk_tgt(0, 0, 'h7FF); ie[0] = 1'b1;
    tgt[3] = mk_tgt(1, 0, 'h03); tgt[60] = mk_tgt(4, 0, 'h3C); tgt[1] = mk_tgt(0, 0, 'h01);
    @(posedge clk); #1 msi_rdy = 1'b0;
    set_ip((NR_SRC'(1) << 3) | (NR_SRC'(1) << 60) | NR_SRC'(1));
    wait_valid("t2_valid");
    saved = msi_addr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_stall_valid", 64'(msi_v), 64'd1);
      check("t2_stall_addr", msi_addr, saved);
    end
    @(posedge clk); #1 msi_rdy = 1'b1;
    wait_events(2, "t2_two_events");
    set_ip(NR_SRC'(1) << 1);
    wait_events(3, "t2_wrap_event");
    if (ev_q.size() >= 3) begin
      check("t2_first_idx", 64'(ev_q[0].idx), 64'd3);
      check("t2_first_addr", ev_q[0].addr, 64'h2800_1000);
      check("t2_second_idx", 64'(ev_q[1].idx), 64'd60);
      check("t2_second_data", 64'(ev_q[1].data), 64'h3C);
      check("t2_wrap_idx", 64'(ev_q[2].idx), 64'd1);
    end
    ie[0] = 1'b0;

    // 3: genmsi priority, busy readback, write during busy ignored
    do_reset();
    lhxs = 3'd2; tgt[9] = mk_tgt(5, 0, 'h45);
    @(posedge clk); #1 msi_rdy = 1'b0;
    gm_we = 1'b1; gm_wdata = mk_tgt(1, 0, 7); ip_set = NR_SRC'(1) << 9;
    @(posedge clk); #1 gm_we = 1'b0; ip_set = '0;
    wait_valid("t3_valid");
    check("t3_busy_readback", 64'(genmsi), 64'h0004_1007);
    genmsi_write(2, 9);
    @(negedge clk);
    check("t3_write_ignored", 64'(genmsi), 64'h0004_1007);
    @(posedge clk); #1 msi_rdy = 1'b1;
    wait_events(2, "t3_events");
    if (ev_q.size() >= 2) begin
      check("t3_first_kind", 64'(ev_q[0].kind), 64'(K_GM));
      check("t3_gm_addr", ev_q[0].addr, 64'h2800_4000);
      check("t3_gm_data", 64'(ev_q[0].data), 64'd7);
      check("t3_then_src9", 64'(ev_q[1].idx), 64'd9);
    end
    check("t3_busy_cleared", 64'(genmsi[12]), 64'd0);

    // 4: EIID 0 retires the source without a write
    do_reset();
    lhxs = 3'd3; tgt[4] = mk_tgt(1, 0, 0); tgt[6] = mk_tgt(2, 1, 'h33);
    set_ip((NR_SRC'(1) << 4) | (NR_SRC'(1) << 6));
    wait_events(2, "t4_events");
    if (ev_q.size() >= 2) begin
      check("t4_zero_kind", 64'(ev_q[0].kind), 64'(K_ZERO));
      check("t4_zero_idx", 64'(ev_q[0].idx), 64'd4);
      check("t4_next_idx", 64'(ev_q[1].idx), 64'd6);
      check("t4_next_addr", ev_q[1].addr, 64'h2801_1000);
    end
    check("t4_ip4_cleared", 64'(ip_q[4]), 64'd0);

    // 5: DM=0 idles; async reset mid-SEND abandons and later re-sends
    do_reset();
    lhxs = 3'd0; dc_dm = 1'b0;
    set_ip(NR_SRC'(1) << 5);
    n = rd_cnt + v_cnt;
    repeat (30) @(negedge clk);
    check("t5_dm0_quiet", 64'(rd_cnt + v_cnt - n), 64'd0);
    check("t5_dm0_no_events", 64'(ev_q.size()), 64'd0);
    @(posedge clk); #1 msi_rdy = 1'b0; dc_dm = 1'b1;
    wait_valid("t5_valid");
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid_drop", 64'(msi_v), 64'd0);
    check("t5_async_no_clr", 64'(clr_v), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("t5_ip_kept", 64'(ip_q[5]), 64'd1);
    check("t5_no_event_at_reset", 64'(ev_q.size()), 64'd0);
    msi_rdy = 1'b1;
    wait_events(1, "t5_resend");
    if (ev_q.size() >= 1) check("t5_resend_idx", 64'(ev_q[0].idx), 64'd5);

    // 6: pending dropped during target read aborts in LATCH
    do_reset();
    tgt[7] = mk_tgt(2, 3, 'h17);
    set_ip(NR_SRC'(1) << 7);
    n = 0;
    while (!(rd_en && rd_idx == 7) && n < 100) begin @(negedge clk); n++; end
    check("t6_rd_seen", 64'(rd_en && rd_idx == 7), 64'd1);
    ip_kill[7] = 1'b1;
    @(posedge clk); #1 ip_kill = '0;
    repeat (30) @(negedge clk);
    check("t6_no_events", 64'(ev_q.size()), 64'd0);
    set_ip(NR_SRC'(1) << 7);
    wait_events(1, "t6_scan_continues");

    // Randomized rounds, each ending with a bounded drain
    for (int r = 0; r < 4; r++) begin
      do_reset();
      lhxs = 3'($urandom_range(0, 7));
      base = {32'($urandom), 32'($urandom)} & ~64'hFFF;
      ie = {32'($urandom), 32'($urandom)};
      for (int i = 1; i < NR_SRC; i++)
        tgt[i] = mk_tgt($urandom, $urandom, ($urandom_range(0, 5) == 0) ? 0 : $urandom);
      for (int c = 0; c < 500; c++) begin
        @(posedge clk); #1;
        ip_set = ($urandom_range(0, 4) == 0) ?
                 ({32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)} &
                  {32'($urandom), 32'($urandom)} & ~NR_SRC'(1)) : '0;
        msi_rdy = ($urandom_range(0, 3) != 0);
        gm_we = ($urandom_range(0, 19) == 0);
        gm_wdata = $urandom;
      end
      @(posedge clk); #1 ip_set = '0; gm_we = 1'b0; msi_rdy = 1'b1;
      n = 0;
      while (((ip_q & ie & ~NR_SRC'(1)) != '0 || genmsi[12] || msi_v) && n < 4000) begin
        @(negedge clk); n++;
      end
      check("rand_drain_complete", 64'((ip_q & ie & ~NR_SRC'(1)) == '0 && !genmsi[12]), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
